// File: rtl/sound_sequencer.sv
// rtl/sound_sequencer.sv - event-triggered melody sequencer driving a tone generator
module sound_sequencer #(
  parameter int NUM_EVENTS = 4,
  parameter int MAX_NOTES  = 4,
  parameter int NOTE_W     = 4,
  parameter int DUR_W      = 5,
  parameter int TICK_DIV   = 16,
  localparam int EV_W = (NUM_EVENTS > 1) ? $clog2(NUM_EVENTS) : 1,
  localparam int ST_W = (MAX_NOTES > 1) ? $clog2(MAX_NOTES) : 1,
  localparam int AW   = (NUM_EVENTS * MAX_NOTES > 1) ? $clog2(NUM_EVENTS * MAX_NOTES) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_EVENTS-1:0] event_in,
  input  logic                  tbl_we,
  input  logic [AW-1:0]         tbl_addr,
  input  logic [NOTE_W-1:0]     tbl_note,
  input  logic [DUR_W-1:0]      tbl_dur,
  output logic                  enabled,
  output logic [NOTE_W-1:0]     divisor,
  output logic                  busy,
  output logic [EV_W-1:0]       active_event,
  output logic                  done
);

  localparam int DEPTH = NUM_EVENTS * MAX_NOTES;
  localparam int TW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [TW-1:0]    TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [TW-1:0]    TICK_ONE  = TW'(1);
  localparam logic [ST_W-1:0]  STEP_LAST = ST_W'(MAX_NOTES - 1);
  localparam logic [ST_W-1:0]  STEP_ONE  = ST_W'(1);
  localparam logic [DUR_W-1:0] DUR_ONE   = DUR_W'(1);
  localparam logic [AW:0]      DEPTH_EXT = (AW + 1)'(DEPTH);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_PLAY = 1'b1
  } state_t;

  // Event input conditioning
  logic [NUM_EVENTS-1:0] sync1;
  logic [NUM_EVENTS-1:0] sync2;
  logic [NUM_EVENTS-1:0] prev;
  logic [NUM_EVENTS-1:0] armed;
  logic [1:0]            prime;
  logic [NUM_EVENTS-1:0] trig;

  // Note table
  logic [NOTE_W-1:0] note_mem [DEPTH];
  logic [DUR_W-1:0]  dur_mem  [DEPTH];

  // Arbitration and load selection
  logic            win_valid;
  logic [EV_W-1:0] win_idx;
  logic            take_trig;
  logic            tick;
  logic            last_step;
  logic [EV_W-1:0] load_ev;
  logic [ST_W-1:0] load_step;
  logic [AW-1:0]   rd_addr;
  logic [NOTE_W-1:0] ld_note;
  logic [DUR_W-1:0]  ld_dur;

  // Sequencer state
  state_t            state, state_d;
  logic [TW-1:0]     tick_cnt, tick_d;
  logic [DUR_W-1:0]  dur_cnt, dur_d;
  logic [ST_W-1:0]   step, step_d;
  logic              enabled_d;
  logic [NOTE_W-1:0] divisor_d;
  logic              busy_d;
  logic [EV_W-1:0]   active_d;
  logic              done_d;
  logic              do_load;

  // Two-flop synchroniser plus previous-value flop for rising-edge detection.
  // A channel is armed only after its synchronised level has been seen low
  // once the pipeline is primed, so a level already high at reset release
  // never counts as a new edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
      armed <= '0;
      prime <= '0;
    end else begin
      sync1 <= event_in;
      sync2 <= sync1;
      prev  <= sync2;
      prime <= {prime[0], 1'b1};
      if (prime[1]) begin
        armed <= armed | ~sync2;
      end
    end
  end

  assign trig = sync2 & ~prev & armed;

  // Lowest set trigger index wins; the rest are dropped.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    for (int i = NUM_EVENTS - 1; i >= 0; i--) begin
      if (trig[i]) begin
        win_valid = 1'b1;
        win_idx   = EV_W'(i);
      end
    end
  end

  // Registered table writes; out-of-range addresses are discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        note_mem[i] <= '0;
        dur_mem[i]  <= '0;
      end
    end else if (tbl_we && ({1'b0, tbl_addr} < DEPTH_EXT)) begin
      note_mem[tbl_addr] <= tbl_note;
      dur_mem[tbl_addr]  <= tbl_dur;
    end
  end

  // Decide which table entry a load would read this cycle.
  always_comb begin
    take_trig = win_valid && ((state == S_IDLE) || (win_idx <= active_event));
    tick      = (tick_cnt == TICK_LAST);
    last_step = (step == STEP_LAST);
    load_ev   = take_trig ? win_idx : active_event;
    load_step = take_trig ? '0 : (step + STEP_ONE);
    rd_addr   = AW'(int'(load_ev) * MAX_NOTES + int'(load_step));
    ld_note   = note_mem[rd_addr];
    ld_dur    = dur_mem[rd_addr];
  end

  // Next-state logic: a trigger outranks the natural advance of the melody.
  always_comb begin
    state_d   = state;
    enabled_d = enabled;
    divisor_d = divisor;
    busy_d    = busy;
    active_d  = active_event;
    done_d    = 1'b0;
    tick_d    = tick_cnt;
    dur_d     = dur_cnt;
    step_d    = step;
    do_load   = 1'b0;

    if (take_trig) begin
      do_load = 1'b1;
    end else if (state == S_PLAY) begin
      if (tick) begin
        tick_d = '0;
        if (dur_cnt == DUR_ONE) begin
          if (last_step) begin
            state_d   = S_IDLE;
            enabled_d = 1'b0;
            divisor_d = '0;
            busy_d    = 1'b0;
            dur_d     = '0;
            step_d    = '0;
            done_d    = 1'b1;
          end else begin
            do_load = 1'b1;
          end
        end else begin
          dur_d = dur_cnt - DUR_ONE;
        end
      end else begin
        tick_d = tick_cnt + TICK_ONE;
      end
    end

    if (do_load) begin
      if (ld_dur == '0) begin
        // End marker: a natural advance reports completion, a trigger does not.
        state_d   = S_IDLE;
        enabled_d = 1'b0;
        divisor_d = '0;
        busy_d    = 1'b0;
        tick_d    = '0;
        dur_d     = '0;
        step_d    = '0;
        done_d    = ~take_trig;
      end else begin
        state_d   = S_PLAY;
        divisor_d = ld_note;
        enabled_d = (ld_note != '0);
        busy_d    = 1'b1;
        active_d  = load_ev;
        dur_d     = ld_dur;
        tick_d    = '0;
        step_d    = load_step;
      end
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      tick_cnt     <= '0;
      dur_cnt      <= '0;
      step         <= '0;
      enabled      <= 1'b0;
      divisor      <= '0;
      busy         <= 1'b0;
      active_event <= '0;
      done         <= 1'b0;
    end else begin
      state        <= state_d;
      tick_cnt     <= tick_d;
      dur_cnt      <= dur_d;
      step         <= step_d;
      enabled      <= enabled_d;
      divisor      <= divisor_d;
      busy         <= busy_d;
      active_event <= active_d;
      done         <= done_d;
    end
  end

endmodule

// File: tb/tb_sound_sequencer.sv
// tb/tb_sound_sequencer.sv - directed self-checking bench for sound_sequencer
module tb_sound_sequencer;

  logic       clk;
  logic       rst_n;
  logic [3:0] event_in;
  logic       tbl_we;
  logic [3:0] tbl_addr;
  logic [3:0] tbl_note;
  logic [4:0] tbl_dur;
  logic       enabled;
  logic [3:0] divisor;
  logic       busy;
  logic [1:0] active_event;
  logic       done;

  int n_vec;
  int n_err;

  sound_sequencer #(
    .NUM_EVENTS(4),
    .MAX_NOTES (4),
    .NOTE_W    (4),
    .DUR_W     (5),
    .TICK_DIV  (4)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .event_in    (event_in),
    .tbl_we      (tbl_we),
    .tbl_addr    (tbl_addr),
    .tbl_note    (tbl_note),
    .tbl_dur     (tbl_dur),
    .enabled     (enabled),
    .divisor     (divisor),
    .busy        (busy),
    .active_event(active_event),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view: {enabled, busy, done, active_event[1:0], divisor[3:0]}
  function automatic logic [8:0] obs();
    return {enabled, busy, done, active_event, divisor};
  endfunction

  function automatic logic [8:0] exp_o(input bit en, input bit bz, input bit dn,
                                       input int ev, input int dv);
    return {en, bz, dn, 2'(ev), 4'(dv)};
  endfunction

  task automatic check(input string tag, input logic [8:0] got, input logic [8:0] expv);
    n_vec++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s: got en/busy/done/ev/div=%b expected %b", tag, got, expv);
    end
  endtask

  task automatic tbl_write(input int a, input int n, input int d);
    @(negedge clk);
    tbl_we   = 1'b1;
    tbl_addr = 4'(a);
    tbl_note = 4'(n);
    tbl_dur  = 5'(d);
    @(negedge clk);
    tbl_we   = 1'b0;
  endtask

  initial begin
    logic [8:0] e;
    n_vec    = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    event_in = '0;
    tbl_we   = 1'b0;
    tbl_addr = '0;
    tbl_note = '0;
    tbl_dur  = '0;

    repeat (2) @(negedge clk);
    check("reset", obs(), exp_o(0, 0, 0, 0, 0));
    rst_n = 1'b1;

    // ev0 {8,2},{4,2},{8,1},end ; ev1 {9,1},{11,1},end ; ev2 {3,2},{5,2},{7,2},end
    tbl_write(0, 8, 2);
    tbl_write(1, 4, 2);
    tbl_write(2, 8, 1);
    tbl_write(3, 9, 0);
    tbl_write(4, 9, 1);
    tbl_write(5, 11, 1);
    tbl_write(8, 3, 2);
    tbl_write(9, 5, 2);
    tbl_write(10, 7, 2);

    // Basic ev0 melody
    @(negedge clk);
    event_in[0] = 1'b1;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 22; s++) begin
      @(negedge clk);
      if (s < 8)       e = exp_o(1, 1, 0, 0, 8);
      else if (s < 16) e = exp_o(1, 1, 0, 0, 4);
      else if (s < 20) e = exp_o(1, 1, 0, 0, 8);
      else if (s == 20) e = exp_o(0, 0, 1, 0, 0);
      else             e = exp_o(0, 0, 0, 0, 0);
      check($sformatf("ev0_melody[%0d]", s), obs(), e);
    end
    event_in = '0;
    repeat (3) @(negedge clk);

    // ev2 preempted by ev1; ev3 during ev1 is dropped
    event_in[2] = 1'b1;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      check($sformatf("ev2_start[%0d]", s), obs(), exp_o(1, 1, 0, 2, 3));
    end
    event_in[1] = 1'b1;
    for (int u = 0; u < 12; u++) begin
      @(negedge clk);
      if (u < 2)        e = exp_o(1, 1, 0, 2, 3);
      else if (u < 6)   e = exp_o(1, 1, 0, 1, 9);
      else if (u < 10)  e = exp_o(1, 1, 0, 1, 11);
      else if (u == 10) e = exp_o(0, 0, 1, 1, 0);
      else              e = exp_o(0, 0, 0, 1, 0);
      check($sformatf("preempt[%0d]", u), obs(), e);
      if (u == 2) event_in = 4'b1000;
    end
    event_in = '0;
    repeat (4) @(negedge clk);

    // Simultaneous ev1 and ev2: only ev1 plays
    event_in = 4'b0110;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 10; s++) begin
      @(negedge clk);
      if (s < 4)       e = exp_o(1, 1, 0, 1, 9);
      else if (s < 8)  e = exp_o(1, 1, 0, 1, 11);
      else if (s == 8) e = exp_o(0, 0, 1, 1, 0);
      else             e = exp_o(0, 0, 0, 1, 0);
      check($sformatf("simul[%0d]", s), obs(), e);
    end
    event_in = '0;

    // ev3: rest {0,3} then {5,1}
    tbl_write(12, 0, 3);
    tbl_write(13, 5, 1);
    @(negedge clk);
    event_in[3] = 1'b1;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 18; s++) begin
      @(negedge clk);
      if (s < 12)       e = exp_o(0, 1, 0, 3, 0);
      else if (s < 16)  e = exp_o(1, 1, 0, 3, 5);
      else if (s == 16) e = exp_o(0, 0, 1, 3, 0);
      else              e = exp_o(0, 0, 0, 3, 0);
      check($sformatf("rest[%0d]", s), obs(), e);
    end
    event_in = '0;

    // ev3 empty melody: no output change, no done
    tbl_write(12, 0, 0);
    repeat (2) @(negedge clk);
    event_in[3] = 1'b1;
    for (int s = 0; s < 8; s++) begin
      @(negedge clk);
      check($sformatf("empty[%0d]", s), obs(), exp_o(0, 0, 0, 3, 0));
    end
    event_in = '0;

    // All four ev0 entries dur=1, with live table edits during playback
    tbl_write(0, 1, 1);
    tbl_write(1, 2, 1);
    tbl_write(2, 3, 1);
    tbl_write(3, 4, 1);
    @(negedge clk);
    event_in[0] = 1'b1;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 18; s++) begin
      @(negedge clk);
      if (s < 4)        e = exp_o(1, 1, 0, 0, 1);
      else if (s < 8)   e = exp_o(1, 1, 0, 0, 2);
      else if (s < 12)  e = exp_o(1, 1, 0, 0, 7);
      else if (s < 16)  e = exp_o(1, 1, 0, 0, 4);
      else if (s == 16) e = exp_o(0, 0, 1, 0, 0);
      else              e = exp_o(0, 0, 0, 0, 0);
      check($sformatf("full[%0d]", s), obs(), e);
      if (s == 0) begin
        tbl_we = 1'b1; tbl_addr = 4'd0; tbl_note = 4'd6; tbl_dur = 5'd1;
      end else if (s == 1) begin
        tbl_we = 1'b1; tbl_addr = 4'd2; tbl_note = 4'd7; tbl_dur = 5'd1;
      end else if (s == 2) begin
        tbl_we = 1'b0;
      end
    end
    event_in = '0;
    repeat (3) @(negedge clk);

    // Reset mid-note, event held high across release
    event_in[0] = 1'b1;
    repeat (2) @(negedge clk);
    @(negedge clk);
    check("pre_reset", obs(), exp_o(1, 1, 0, 0, 6));
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", obs(), exp_o(0, 0, 0, 0, 0));
    @(negedge clk);
    check("in_reset", obs(), exp_o(0, 0, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;
    tbl_write(0, 6, 1);
    for (int s = 0; s < 6; s++) begin
      @(negedge clk);
      check($sformatf("held_high[%0d]", s), obs(), exp_o(0, 0, 0, 0, 0));
    end
    event_in[0] = 1'b0;
    repeat (3) @(negedge clk);
    event_in[0] = 1'b1;
    repeat (2) @(negedge clk);
    @(negedge clk);
    check("retrigger", obs(), exp_o(1, 1, 0, 0, 6));
    event_in = '0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
